wb_stage_multi: RTL

WB_STAGE_MULTI -- requirements
Module: wb_stage_multi

---
 rtl/wb_stage_multi_pkg.sv | 25 ++
 rtl/wb_stage_multi_if.sv | 44 ++++
 rtl/wb_stage_multi_redirect_sel.sv | 31 +++
 rtl/wb_stage_multi.sv | 108 ++++++++++
 4 files changed

// File: rtl/wb_stage_multi_pkg.sv
// wb_pkg: shared defaults, per-lane writeback record and popcount helper for the writeback stage.
// Ports: none (package).
package wb_pkg;

    localparam int DEF_XLEN  = 64;
    localparam int DEF_SID_W = 4;
    localparam int MAX_LANES = 64;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           rd;
        logic [DEF_XLEN-1:0]  value;
        logic [DEF_XLEN-1:0]  pc;
        logic [31:0]          inst;
        logic [DEF_SID_W-1:0] sid;
    } wb_lane_t;

    function automatic logic [6:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) n = n + 7'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/wb_stage_multi_if.sv
// wb_stage_multi_if: input group and output group handshake bus of the writeback stage.
// Ports: in_valid_i/in_ready_o + per-lane input fields (valid, redirect, rd, value, pc,
//        redirect_pc, inst, sid); out_valid_o/out_ready_i + per-lane output fields
//        (valid, wen, rd, value, pc, inst, sid). Lane k lives at slice k.
//        master = environment side, slave = the stage.
interface wb_stage_multi_if #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = wb_pkg::DEF_XLEN,
    parameter int SID_W     = wb_pkg::DEF_SID_W
);
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [NUM_LANES-1:0]       lane_valid_i;
    logic [NUM_LANES-1:0]       lane_redirect_i;
    logic [NUM_LANES*5-1:0]     lane_rd_i;
    logic [NUM_LANES*XLEN-1:0]  lane_value_i;
    logic [NUM_LANES*XLEN-1:0]  lane_pc_i;
    logic [NUM_LANES*XLEN-1:0]  lane_redirect_pc_i;
    logic [NUM_LANES*32-1:0]    lane_inst_i;
    logic [NUM_LANES*SID_W-1:0] lane_sid_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [NUM_LANES-1:0]       lane_valid_o;
    logic [NUM_LANES-1:0]       lane_wen_o;
    logic [NUM_LANES*5-1:0]     lane_rd_o;
    logic [NUM_LANES*XLEN-1:0]  lane_value_o;
    logic [NUM_LANES*XLEN-1:0]  lane_pc_o;
    logic [NUM_LANES*32-1:0]    lane_inst_o;
    logic [NUM_LANES*SID_W-1:0] lane_sid_o;

    modport master (
        output in_valid_i, lane_valid_i, lane_redirect_i, lane_rd_i, lane_value_i, lane_pc_i,
               lane_redirect_pc_i, lane_inst_i, lane_sid_i, out_ready_i,
        input  in_ready_o, out_valid_o, lane_valid_o, lane_wen_o, lane_rd_o, lane_value_o,
               lane_pc_o, lane_inst_o, lane_sid_o
    );

    modport slave (
        input  in_valid_i, lane_valid_i, lane_redirect_i, lane_rd_i, lane_value_i, lane_pc_i,
               lane_redirect_pc_i, lane_inst_i, lane_sid_i, out_ready_i,
        output in_ready_o, out_valid_o, lane_valid_o, lane_wen_o, lane_rd_o, lane_value_o,
               lane_pc_o, lane_inst_o, lane_sid_o
    );
endinterface

// File: rtl/wb_stage_multi_redirect_sel.sv
// wb_redirect_sel: finds the oldest valid lane requesting a redirect, squashes younger lanes, muxes its pc.
// Ports: lane_valid, lane_redirect (per lane), lane_redirect_pc (flat) in;
//        keep (surviving lane valids), hit (any redirect), redirect_pc out.
module wb_redirect_sel #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 64
) (
    input  logic [NUM_LANES-1:0]      lane_valid,
    input  logic [NUM_LANES-1:0]      lane_redirect,
    input  logic [NUM_LANES*XLEN-1:0] lane_redirect_pc,
    output logic [NUM_LANES-1:0]      keep,
    output logic                      hit,
    output logic [XLEN-1:0]           redirect_pc
);
    logic found;

    // found flips on the first redirecting lane; that lane still retires, later ones are dropped
    always_comb begin
        found       = 1'b0;
        keep        = '0;
        redirect_pc = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            keep[k]     = lane_valid[k] && !found;
            redirect_pc = (!found && lane_valid[k] && lane_redirect[k]) ? lane_redirect_pc[k*XLEN +: XLEN] : redirect_pc;
            found       = found || (lane_valid[k] && lane_redirect[k]);
        end
    end

    assign hit = found;

endmodule

// File: rtl/wb_stage_multi.sv
// wb_stage_multi: multi-lane writeback pipeline register with redirect select and retire counters.
// Ports: clk, rst (sync active-high); bus (slave side of wb_stage_multi_if: input group in,
//        registered output group out); flush_i; redirect_o/redirect_pc_o frontend redirect pulse;
//        retired_cnt_o, redirect_cnt_o wrapping performance counters.
module wb_stage_multi
    import wb_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = DEF_XLEN,
    parameter int SID_W     = DEF_SID_W,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_stage_multi_if.slave  bus,
    input  logic             flush_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);
    logic [NUM_LANES-1:0]       valid_q;
    logic [NUM_LANES*5-1:0]     rd_q;
    logic [NUM_LANES*XLEN-1:0]  value_q;
    logic [NUM_LANES*XLEN-1:0]  pc_q;
    logic [NUM_LANES*32-1:0]    inst_q;
    logic [NUM_LANES*SID_W-1:0] sid_q;
    logic                       redirect_q;
    logic [XLEN-1:0]            redirect_pc_q;
    logic [CNT_W-1:0]           retired_q;
    logic [CNT_W-1:0]           redir_cnt_q;
    logic [NUM_LANES-1:0]       keep;
    logic                       sel_hit;
    logic [XLEN-1:0]            sel_pc;
    logic                       out_valid;
    logic                       in_ready;
    logic                       in_fire;
    logic                       out_fire;

    wb_redirect_sel #(
        .NUM_LANES (NUM_LANES),
        .XLEN      (XLEN)
    ) u_sel (
        .lane_valid       (bus.lane_valid_i),
        .lane_redirect    (bus.lane_redirect_i),
        .lane_redirect_pc (bus.lane_redirect_pc_i),
        .keep             (keep),
        .hit              (sel_hit),
        .redirect_pc      (sel_pc)
    );

    assign out_valid = |valid_q;
    assign in_ready  = !out_valid || bus.out_ready_i;
    assign in_fire   = bus.in_valid_i && in_ready && !flush_i;
    assign out_fire  = out_valid && bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            rd_q          <= '0;
            value_q       <= '0;
            pc_q          <= '0;
            inst_q        <= '0;
            sid_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            retired_q     <= '0;
            redir_cnt_q   <= '0;
        end else begin
            // the pulse is tied to capture only, so a stalled group never re-asserts it
            redirect_q <= in_fire && sel_hit;
            if (in_fire && sel_hit) redirect_pc_q <= sel_pc;
            if (redirect_q) redir_cnt_q <= redir_cnt_q + 1'b1;
            if (out_fire) retired_q <= retired_q + CNT_W'(popcount(MAX_LANES'(valid_q)));
            if (flush_i) begin
                valid_q <= '0;
            end else if (in_fire) begin
                valid_q <= keep;
                rd_q    <= bus.lane_rd_i;
                value_q <= bus.lane_value_i;
                pc_q    <= bus.lane_pc_i;
                inst_q  <= bus.lane_inst_i;
                sid_q   <= bus.lane_sid_i;
            end else if (out_fire) begin
                valid_q <= '0;
            end
        end
    end

    always_comb begin
        bus.lane_wen_o = '0;
        for (int k = 0; k < NUM_LANES; k++) bus.lane_wen_o[k] = valid_q[k] && (rd_q[k*5 +: 5] != 5'd0);
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.out_valid_o  = out_valid;
    assign bus.lane_valid_o = valid_q;
    assign bus.lane_rd_o    = rd_q;
    assign bus.lane_value_o = value_q;
    assign bus.lane_pc_o    = pc_q;
    assign bus.lane_inst_o  = inst_q;
    assign bus.lane_sid_o   = sid_q;
    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign retired_cnt_o    = retired_q;
    assign redirect_cnt_o   = redir_cnt_q;

endmodule
